// File: rtl/sprite_pkg.sv
// Shared constants, types and helpers for the sprite position controller and draw stage.
// Positions are unsigned 11-bit; the clamp limits keep a 64x64 sprite fully inside the active area.
package sprite_pkg;

    localparam int POS_W    = 11;
    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 600;
    localparam int SPR_W    = 64;
    localparam int SPR_H    = 64;

    typedef logic [POS_W-1:0] pos_t;

    localparam pos_t X_MAX = POS_W'(H_ACTIVE - SPR_W);
    localparam pos_t Y_MAX = POS_W'(V_ACTIVE - SPR_H);

    localparam logic [11:0] TRANSPARENT_COLOUR = 12'hfac;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    function automatic pos_t clamp_pos(input pos_t v, input pos_t lim);
        return (v > lim) ? lim : v;
    endfunction

    // Adds a 5-bit signed step in 12-bit signed arithmetic, saturating to [0, lim].
    function automatic pos_t sat_step(input pos_t p, input logic [4:0] v, input pos_t lim);
        logic [11:0] sum;
        sum = {1'b0, p} + {{7{v[4]}}, v};
        if (sum[11])
            return '0;
        else if (sum[10:0] > lim)
            return lim;
        else
            return sum[10:0];
    endfunction

endpackage

// File: rtl/sprite_pos_ctrl_if.sv
// Command channel from game logic: valid/ready handshake carrying a position and visibility.
interface sprite_pos_ctrl_if;
    import sprite_pkg::*;

    logic cmd_valid;
    logic cmd_ready;
    pos_t cmd_x;
    pos_t cmd_y;
    logic cmd_vis;

    modport master (output cmd_valid, output cmd_x, output cmd_y, output cmd_vis, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_x, input cmd_y, input cmd_vis, output cmd_ready);

endinterface

// File: rtl/sprite_pos_ctrl_vblnk_edge.sv
// Registered rising-edge detector on vertical blanking; vb_rise is high in the first blanking cycle.
module vblnk_edge (
    input  logic clk,
    input  logic rst,
    input  logic vblnk_in,
    output logic vb_rise
);

    logic vblnk_q;

    always_ff @(posedge clk) begin
        if (rst)
            vblnk_q <= 1'b0;
        else
            vblnk_q <= vblnk_in;
    end

    assign vb_rise = vblnk_in & ~vblnk_q;

endmodule

// File: rtl/sprite_pos_ctrl.sv
// Buffers one clamped position command and commits it one cycle after the vblank rising edge.
// cmd_ready is low while a command waits; SPRITE_POS_VEL_EN adds per-frame velocity stepping.
module sprite_pos_ctrl
    import sprite_pkg::*;
#(
    parameter pos_t X_RESET = 11'd368,
    parameter pos_t Y_RESET = 11'd268
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             vblnk_in,
    sprite_pos_ctrl_if.slave cmd,
`ifdef SPRITE_POS_VEL_EN
    input  logic [4:0]       vel_x,
    input  logic [4:0]       vel_y,
`endif
    output pos_t             xpos,
    output pos_t             ypos,
    output logic             visible,
    output logic [15:0]      frame_cnt,
    output logic             commit_pulse
);

    state_t state_q, state_d;
    logic   vb_rise;
    logic   capture;
    logic   commit;
    pos_t   pend_x, pend_y;
    logic   pend_vis;

    vblnk_edge u_vblnk_edge (
        .clk      (pclk),
        .rst      (rst),
        .vblnk_in (vblnk_in),
        .vb_rise  (vb_rise)
    );

    always_ff @(posedge pclk) begin
        if (rst)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    // A command captured in the vb_rise cycle waits for the following edge,
    // because the commit decision only looks at PENDING.
    always_comb begin
        state_d       = state_q;
        cmd.cmd_ready = 1'b0;
        capture       = 1'b0;
        commit        = 1'b0;
        unique case (state_q)
            EMPTY: begin
                cmd.cmd_ready = 1'b1;
                if (cmd.cmd_valid) begin
                    capture = 1'b1;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (vb_rise) begin
                    commit  = 1'b1;
                    state_d = COMMIT;
                end
            end
            COMMIT:  state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            pend_x    <= '0;
            pend_y    <= '0;
            pend_vis  <= 1'b0;
            xpos      <= X_RESET;
            ypos      <= Y_RESET;
            visible   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (vb_rise)
                frame_cnt <= frame_cnt + 16'd1;
            if (capture) begin
                pend_x   <= clamp_pos(cmd.cmd_x, X_MAX);
                pend_y   <= clamp_pos(cmd.cmd_y, Y_MAX);
                pend_vis <= cmd.cmd_vis;
            end
            if (commit) begin
                xpos    <= pend_x;
                ypos    <= pend_y;
                visible <= pend_vis;
            end
`ifdef SPRITE_POS_VEL_EN
            else if (vb_rise && state_q == EMPTY) begin
                xpos <= sat_step(xpos, vel_x, X_MAX);
                ypos <= sat_step(ypos, vel_y, Y_MAX);
            end
`endif
        end
    end

`ifdef SPRITE_POS_VEL_EN
    logic vel_go;

    always_ff @(posedge pclk) begin
        if (rst)
            vel_go <= 1'b0;
        else
            vel_go <= vb_rise && (state_q == EMPTY);
    end

    assign commit_pulse = (state_q == COMMIT) | vel_go;
`else
    assign commit_pulse = (state_q == COMMIT);
`endif

endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// Directed table, reset corner sequence and randomized traffic against a frame-level model.
module tb_sprite_pos_ctrl;
    import sprite_pkg::*;

    localparam int XL = 800 - 64;
    localparam int YL = 600 - 64;

    logic        pclk = 1'b0;
    logic        rst;
    logic        vblnk_in;
    pos_t        xpos, ypos;
    logic        visible;
    logic [15:0] frame_cnt;
    logic        commit_pulse;

    sprite_pos_ctrl_if cmd_if ();

`ifdef SPRITE_POS_VEL_EN
    logic [4:0] vel_x = 5'd0;
    logic [4:0] vel_y = 5'd0;
`endif

    sprite_pos_ctrl dut (
        .pclk         (pclk),
        .rst          (rst),
        .vblnk_in     (vblnk_in),
        .cmd          (cmd_if.slave),
`ifdef SPRITE_POS_VEL_EN
        .vel_x        (vel_x),
        .vel_y        (vel_y),
`endif
        .xpos         (xpos),
        .ypos         (ypos),
        .visible      (visible),
        .frame_cnt    (frame_cnt),
        .commit_pulse (commit_pulse)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int ex, input int ey, input int ev,
                              input int er, input int ep, input int efc);
        chk({tag, ".xpos"},      int'(xpos),             ex);
        chk({tag, ".ypos"},      int'(ypos),             ey);
        chk({tag, ".visible"},   int'(visible),          ev);
        chk({tag, ".cmd_ready"}, int'(cmd_if.cmd_ready), er);
        chk({tag, ".pulse"},     int'(commit_pulse),     ep);
        chk({tag, ".frame_cnt"}, int'(frame_cnt),        efc);
    endtask

    task automatic drive(input int vb, input int valid, input int x, input int y, input int vis);
        vblnk_in         = 1'(vb);
        cmd_if.cmd_valid = 1'(valid);
        cmd_if.cmd_x     = 11'(x);
        cmd_if.cmd_y     = 11'(y);
        cmd_if.cmd_vis   = 1'(vis);
    endtask

    task automatic next_cycle();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset(input int vb);
        rst = 1'b1;
        drive(vb, 0, 0, 0, 0);
        repeat (3) @(posedge pclk);
        #1 rst = 1'b0;
    endtask

    // Frame-level reference: at most one waiting command, applied on the next blanking edge.
    int m_x, m_y, m_vis, m_fc, m_pulse, m_ready, m_vbq, has_pend, p_x, p_y, p_vis;

    task automatic model_reset();
        m_x = 368; m_y = 268; m_vis = 0; m_fc = 0; m_pulse = 0; m_ready = 1;
        m_vbq = 0; has_pend = 0; p_x = 0; p_y = 0; p_vis = 0;
    endtask

    task automatic model_step(input int vb, input int valid, input int x, input int y,
                              input int vis, output int accepted);
        int rise;
        int nxt_pulse;
        rise      = (vb != 0 && m_vbq == 0) ? 1 : 0;
        m_vbq     = vb;
        nxt_pulse = 0;
        accepted  = 0;
        if (rise != 0)
            m_fc = (m_fc + 1) % 65536;
        if (has_pend != 0 && rise != 0) begin
            m_x = p_x; m_y = p_y; m_vis = p_vis;
            has_pend  = 0;
            nxt_pulse = 1;
        end else if (m_ready != 0 && valid != 0) begin
            p_x = (x > XL) ? XL : x;
            p_y = (y > YL) ? YL : y;
            p_vis    = vis;
            has_pend = 1;
            accepted = 1;
        end
        m_pulse = nxt_pulse;
        m_ready = (has_pend == 0 && nxt_pulse == 0) ? 1 : 0;
    endtask

    typedef struct {
        int vb, valid, x, y, vis;
        int ex, ey, ev, er, ep, efc;
    } vec_t;

    vec_t tbl[22];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cur_valid, cur_x, cur_y, cur_vis, vb, acc;

        tbl[0]  = '{0, 1, 100, 50, 1,   368, 268, 0, 1, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0,      368, 268, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 0,      368, 268, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 0,      100, 50,  1, 0, 1, 1};
        tbl[4]  = '{1, 0, 0, 0, 0,      100, 50,  1, 1, 0, 1};
        tbl[5]  = '{0, 1, 900, 700, 0,  100, 50,  1, 1, 0, 1};
        tbl[6]  = '{0, 0, 0, 0, 0,      100, 50,  1, 0, 0, 1};
        tbl[7]  = '{1, 0, 0, 0, 0,      100, 50,  1, 0, 0, 1};
        tbl[8]  = '{0, 0, 0, 0, 0,      736, 536, 0, 0, 1, 2};
        tbl[9]  = '{0, 0, 0, 0, 0,      736, 536, 0, 1, 0, 2};
        tbl[10] = '{1, 1, 10, 20, 1,    736, 536, 0, 1, 0, 2};
        tbl[11] = '{1, 0, 0, 0, 0,      736, 536, 0, 0, 0, 3};
        tbl[12] = '{0, 0, 0, 0, 0,      736, 536, 0, 0, 0, 3};
        tbl[13] = '{1, 0, 0, 0, 0,      736, 536, 0, 0, 0, 3};
        tbl[14] = '{1, 0, 0, 0, 0,      10,  20,  1, 0, 1, 4};
        tbl[15] = '{0, 0, 0, 0, 0,      10,  20,  1, 1, 0, 4};
        tbl[16] = '{0, 1, 200, 300, 1,  10,  20,  1, 1, 0, 4};
        tbl[17] = '{0, 1, 5, 6, 0,      10,  20,  1, 0, 0, 4};
        tbl[18] = '{1, 1, 5, 6, 0,      10,  20,  1, 0, 0, 4};
        tbl[19] = '{1, 1, 5, 6, 0,      200, 300, 1, 0, 1, 5};
        tbl[20] = '{0, 1, 5, 6, 0,      200, 300, 1, 1, 0, 5};
        tbl[21] = '{0, 0, 0, 0, 0,      200, 300, 1, 0, 0, 5};

        do_reset(0);
        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].vb, tbl[i].valid, tbl[i].x, tbl[i].y, tbl[i].vis);
            @(negedge pclk);
            check_outs($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ev,
                       tbl[i].er, tbl[i].ep, tbl[i].efc);
            next_cycle();
        end

        // Reset while a command is pending, with blanking already high at release.
        do_reset(1);
        @(negedge pclk);
        check_outs("rst_rel", 368, 268, 0, 1, 0, 0);
        next_cycle();
        @(negedge pclk);
        check_outs("rst_vb_counted", 368, 268, 0, 1, 0, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        next_cycle();
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk("rst_no_commit.pulse", int'(commit_pulse), 0);
            next_cycle();
        end
        @(negedge pclk);
        check_outs("rst_discard", 368, 268, 0, 1, 0, 2);
        next_cycle();

        // Randomized traffic against the model; submitter holds payload until accepted.
        do_reset(0);
        model_reset();
        cur_valid = 0; cur_x = 0; cur_y = 0; cur_vis = 0; vb = 0;
        for (int n = 0; n < 4000; n++) begin
            if (cur_valid == 0 && $urandom_range(0, 2) == 0) begin
                cur_valid = 1;
                cur_x   = int'($urandom_range(0, 2047));
                cur_y   = int'($urandom_range(0, 2047));
                cur_vis = int'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 7) == 0)
                vb = 1 - vb;
            drive(vb, cur_valid, cur_x, cur_y, cur_vis);
            @(negedge pclk);
            check_outs("rnd", m_x, m_y, m_vis, m_ready, m_pulse, m_fc);
            model_step(vb, cur_valid, cur_x, cur_y, cur_vis, acc);
            if (acc != 0)
                cur_valid = 0;
            next_cycle();
        end

`ifdef SPRITE_POS_VEL_EN
        do_reset(0);
        drive(0, 1, 3, 100, 1);
        next_cycle();
        drive(1, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        @(negedge pclk);
        chk("vel_setup.xpos", int'(xpos), 3);
        vel_x = 5'b11011;
        for (int f = 0; f < 3; f++) begin
            drive(0, 0, 0, 0, 0);
            next_cycle();
            drive(1, 0, 0, 0, 0);
            next_cycle();
            @(negedge pclk);
            chk("vel_sat.xpos", int'(xpos), 0);
            chk("vel_sat.pulse", int'(commit_pulse), 1);
            next_cycle();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
